ofm_write_scheduler: RTL and testbench

Sequences the drain of one finished systolic-array output tile (SYSTOLIC_SIZE channels × up to SYSTOLIC_SIZE pixels) into OFM memory, one word per accepted write. It sits between the array's output buffer and the OFM memory port:
- steps the buffer read selects (channel, pixel);
- generates write enable and address, honouring memory back-pressure;
- tracks the running pixel and channel-group bases across tiles of a layer.

Address arithmetic uses running adders only; there are no multipliers.

---
 rtl/ofm_write_scheduler.sv | 136 +++++++++++++
 tb/tb_ofm_write_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_write_scheduler.sv
// Drains one systolic output tile into OFM memory: walks (channel, pixel) selects,
// issues one address per accepted write and keeps pixel/channel-group bases across tiles.
module ofm_write_scheduler #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE      = 414,
  parameter int ADDR_WIDTH    = 22,
  parameter int NUM_CH_GROUPS = 1,
  parameter int CNT_W         = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  input  logic                  ofm_wr_ready,
  output logic                  ofm_wr_en,
  output logic [ADDR_WIDTH-1:0] ofm_addr,
  output logic [CNT_W-1:0]      rd_ch,
  output logic [CNT_W-1:0]      rd_px,
  output logic                  tile_done,
  output logic                  layer_done,
  output logic                  busy
);
  localparam int                    PLANE_I  = OFM_SIZE * OFM_SIZE;
  localparam logic [ADDR_WIDTH-1:0] PLANE    = ADDR_WIDTH'(PLANE_I);
  localparam logic [ADDR_WIDTH-1:0] GRP_STEP = ADDR_WIDTH'(SYSTOLIC_SIZE * PLANE_I);
  localparam logic [ADDR_WIDTH-1:0] LAST_GRP = ADDR_WIDTH'((NUM_CH_GROUPS - 1) * SYSTOLIC_SIZE * PLANE_I);
  localparam logic [ADDR_WIDTH-1:0] SS       = ADDR_WIDTH'(SYSTOLIC_SIZE);
  localparam logic [CNT_W-1:0]      CH_LAST  = CNT_W'(SYSTOLIC_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WRITE, ADVANCE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      ch_q, ch_d, px_q, px_d;
  logic [CNT_W:0]        vpx_q, vpx_d;
  logic [ADDR_WIDTH-1:0] ch_off_q, ch_off_d, addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] pix_base_q, pix_base_d, grp_base_q, grp_base_d;

  logic [ADDR_WIDTH-1:0] rem;
  logic [CNT_W:0]        vpx_new;
  logic                  accept, px_last, ch_last, plane_end, grp_last;

  // Last tile of a plane may be partial: only the remaining pixels are written.
  assign rem       = PLANE - pix_base_q;
  assign vpx_new   = (rem >= SS) ? (CNT_W+1)'(SYSTOLIC_SIZE) : rem[CNT_W:0];
  assign accept    = (state_q == WRITE) && ofm_wr_ready;
  assign px_last   = ({1'b0, px_q} == vpx_q - (CNT_W+1)'(1));
  assign ch_last   = (ch_q == CH_LAST);
  assign plane_end = (pix_base_q + ADDR_WIDTH'(vpx_q) == PLANE);
  assign grp_last  = (grp_base_q == LAST_GRP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tile_valid) state_d = WRITE;
      WRITE:   if (accept && px_last && ch_last) state_d = ADVANCE;
      ADVANCE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tile_ready = (state_q == IDLE);
    ofm_wr_en  = (state_q == WRITE);
    busy       = (state_q != IDLE);
    tile_done  = (state_q == ADVANCE);
    layer_done = (state_q == ADVANCE) && plane_end && grp_last;
  end

  always_comb begin
    ch_d       = ch_q;
    px_d       = px_q;
    vpx_d      = vpx_q;
    ch_off_d   = ch_off_q;
    addr_d     = addr_q;
    pix_base_d = pix_base_q;
    grp_base_d = grp_base_q;
    case (state_q)
      IDLE: if (tile_valid) begin
        ch_d     = '0;
        px_d     = '0;
        ch_off_d = '0;
        vpx_d    = vpx_new;
        addr_d   = grp_base_q + pix_base_q;
      end
      WRITE: if (accept) begin
        if (!px_last) begin
          px_d   = px_q + CNT_W'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end else if (!ch_last) begin
          px_d     = '0;
          ch_d     = ch_q + CNT_W'(1);
          ch_off_d = ch_off_q + PLANE;
          addr_d   = grp_base_q + pix_base_q + ch_off_q + PLANE;
        end
      end
      ADVANCE: begin
        if (plane_end) begin
          pix_base_d = '0;
          grp_base_d = grp_last ? '0 : grp_base_q + GRP_STEP;
        end else begin
          pix_base_d = pix_base_q + SS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      px_q       <= '0;
      vpx_q      <= '0;
      ch_off_q   <= '0;
      addr_q     <= '0;
      pix_base_q <= '0;
      grp_base_q <= '0;
    end else begin
      ch_q       <= ch_d;
      px_q       <= px_d;
      vpx_q      <= vpx_d;
      ch_off_q   <= ch_off_d;
      addr_q     <= addr_d;
      pix_base_q <= pix_base_d;
      grp_base_q <= grp_base_d;
    end
  end

  assign ofm_addr = addr_q;
  assign rd_ch    = ch_q;
  assign rd_px    = px_q;
endmodule

// File: tb/tb_ofm_write_scheduler.sv
// Bench for ofm_write_scheduler: default 16x414 instance plus a 4x5 instance for plane/layer wrap.
module tb_ofm_write_scheduler;
  localparam int AW  = 22;
  localparam int P_A = 414 * 414;
  localparam int P_B = 5 * 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, tv_a, tv_b, rdy_a, rdy_b;
  logic tr_a, we_a, td_a, ld_a, busy_a;
  logic tr_b, we_b, td_b, ld_b, busy_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [3:0] ch_a, px_a;
  logic [1:0] ch_b, px_b;

  ofm_write_scheduler #(.SYSTOLIC_SIZE(16), .OFM_SIZE(414), .ADDR_WIDTH(AW), .NUM_CH_GROUPS(1)) dut_a (
    .clk(clk), .rst(rst_a), .tile_valid(tv_a), .tile_ready(tr_a), .ofm_wr_ready(rdy_a),
    .ofm_wr_en(we_a), .ofm_addr(addr_a), .rd_ch(ch_a), .rd_px(px_a),
    .tile_done(td_a), .layer_done(ld_a), .busy(busy_a));

  ofm_write_scheduler #(.SYSTOLIC_SIZE(4), .OFM_SIZE(5), .ADDR_WIDTH(AW), .NUM_CH_GROUPS(1)) dut_b (
    .clk(clk), .rst(rst_b), .tile_valid(tv_b), .tile_ready(tr_b), .ofm_wr_ready(rdy_b),
    .ofm_wr_en(we_b), .ofm_addr(addr_b), .rd_ch(ch_b), .rd_px(px_b),
    .tile_done(td_b), .layer_done(ld_b), .busy(busy_b));

  typedef struct {int addr; int ch; int px;} wr_t;
  typedef struct {int dut; int stall_at; int stall_len; int exp_lat; bit exp_layer;} vec_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int nvec = 0, nfail = 0;
  int wcnt_a = 0, wcnt_b = 0;
  int pix[2], grp[2];
  int sz[2] = '{16, 4};
  int pl[2] = '{P_A, P_B};

  logic sel = 1'b0;
  wire          c_ready = sel ? tr_b   : tr_a;
  wire          c_busy  = sel ? busy_b : busy_a;
  wire          c_we    = sel ? we_b   : we_a;
  wire          c_done  = sel ? td_b   : td_a;
  wire          c_layer = sel ? ld_b   : ld_a;
  wire [AW-1:0] c_addr  = sel ? addr_b : addr_a;
  wire [3:0]    c_px    = sel ? {2'b00, px_b} : px_a;

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (!rst_a && we_a && rdy_a) begin
      wcnt_a++;
      if (q_a.size() == 0) chk("a_unexpected_write", longint'(addr_a), -1);
      else begin
        e = q_a.pop_front();
        chk("a_addr", longint'(addr_a), e.addr);
        chk("a_rd_ch", longint'(ch_a), e.ch);
        chk("a_rd_px", longint'(px_a), e.px);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (!rst_b && we_b && rdy_b) begin
      wcnt_b++;
      if (q_b.size() == 0) chk("b_unexpected_write", longint'(addr_b), -1);
      else begin
        e = q_b.pop_front();
        chk("b_addr", longint'(addr_b), e.addr);
        chk("b_rd_ch", longint'(ch_b), e.ch);
        chk("b_rd_px", longint'(px_b), e.px);
      end
    end
  end

  // Expected write order from the plain address rule grp + ch*PLANE + pix + px.
  task automatic push_tile(input int d);
    int vp;
    wr_t w;
    vp = (pl[d] - pix[d] < sz[d]) ? pl[d] - pix[d] : sz[d];
    for (int c = 0; c < sz[d]; c++)
      for (int p = 0; p < vp; p++) begin
        w.addr = grp[d] + c * pl[d] + pix[d] + p;
        w.ch = c;
        w.px = p;
        if (d == 0) q_a.push_back(w); else q_b.push_back(w);
      end
  endtask

  task automatic model_adv(input int d, output bit layer);
    int vp;
    vp = (pl[d] - pix[d] < sz[d]) ? pl[d] - pix[d] : sz[d];
    layer = 1'b0;
    if (pix[d] + vp == pl[d]) begin
      pix[d] = 0;
      grp[d] = 0;
      layer = 1'b1;
    end else pix[d] += sz[d];
  endtask

  task automatic set_rdy(input int d, input logic v);
    if (d == 0) rdy_a = v; else rdy_b = v;
  endtask

  // Starts and ends in the phase #1 after a rising edge, DUT idle.
  task automatic run_tile(input int d, input int stall_at, input int stall_len,
                          output int lat, output bit layer);
    int w0, left, cyc, idx, qs;
    logic [AW-1:0] hold_addr;
    logic [3:0] hold_px;
    bit mlayer;
    sel = (d != 0);
    #0;
    chk("idle_tile_ready", c_ready, 1);
    push_tile(d);
    if (d == 0) tv_a = 1'b1; else tv_b = 1'b1;
    w0 = (d == 0) ? wcnt_a : wcnt_b;
    @(posedge clk); #1;
    if (d == 0) tv_a = 1'b0; else tv_b = 1'b0;
    chk("busy_after_accept", c_busy, 1);
    chk("no_ready_while_busy", c_ready, 0);
    cyc = 1; lat = -1; layer = 1'b0; left = stall_len;
    hold_addr = '0; hold_px = '0;
    while (cyc < 3000) begin
      if (c_done) begin lat = cyc; layer = c_layer; break; end
      idx = ((d == 0) ? wcnt_a : wcnt_b) - w0;
      if (c_we && idx == stall_at && left > 0) begin
        if (left == stall_len) begin hold_addr = c_addr; hold_px = c_px; end
        else begin
          chk("stall_addr_hold", c_addr, hold_addr);
          chk("stall_px_hold", c_px, hold_px);
        end
        set_rdy(d, 1'b0);
        left--;
      end else set_rdy(d, 1'b1);
      @(posedge clk); #1;
      cyc++;
    end
    set_rdy(d, 1'b1);
    if (lat < 0) chk("tile_done_timeout", cyc, -1);
    model_adv(d, mlayer);
    qs = (d == 0) ? q_a.size() : q_b.size();
    chk("writes_all_done", qs, 0);
    @(posedge clk); #1;
    chk("tile_done_one_cycle", c_done, 0);
    chk("idle_after_done", c_ready, 1);
  endtask

  vec_t vt[12];
  int lat, cyc, w0, bad, dcnt;
  bit layer, mlayer;

  initial begin
    vt[0]  = '{0, -1, 0, 257, 1'b0};
    vt[1]  = '{0, -1, 0, 257, 1'b0};
    vt[2]  = '{0,  5, 1, 258, 1'b0};
    for (int i = 3; i < 9; i++) vt[i] = '{1, -1, 0, 17, 1'b0};
    vt[9]  = '{1, -1, 0, 5, 1'b1};
    vt[10] = '{1, -1, 0, 17, 1'b0};
    vt[11] = '{1,  2, 2, 19, 1'b0};

    rst_a = 1; rst_b = 1; tv_a = 0; tv_b = 0; rdy_a = 1; rdy_b = 1;
    pix = '{0, 0}; grp = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tile_ready", tr_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_wr_en", we_a, 0);
    chk("rst_addr", longint'(addr_a), 0);
    chk("rst_rd_ch", longint'(ch_a), 0);
    chk("rst_rd_px", longint'(px_a), 0);
    chk("rst_tile_done", td_a, 0);
    chk("rst_layer_done", ld_a, 0);
    chk("rst_b_ready", tr_b, 1);
    rst_a = 0; rst_b = 0;

    for (int i = 0; i < 12; i++) begin
      run_tile(vt[i].dut, vt[i].stall_at, vt[i].stall_len, lat, layer);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_layer_done", i), layer, vt[i].exp_layer);
    end

    // tile_valid held high across a tile: the next accept happens only in the IDLE cycle.
    sel = 1'b0;
    push_tile(0);
    tv_a = 1'b1;
    @(posedge clk); #1;
    cyc = 1; bad = 0;
    while (!td_a && cyc < 3000) begin
      if (tr_a) bad++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("held_latency", cyc, 257);
    chk("held_ready_while_busy", bad, 0);
    chk("held_layer_done", ld_a, 0);
    model_adv(0, mlayer);
    push_tile(0);
    @(posedge clk); #1;
    chk("held_idle_ready", tr_a, 1);
    chk("held_idle_wr_en", we_a, 0);
    w0 = wcnt_a;
    @(posedge clk); #1;
    tv_a = 1'b0;
    chk("held_second_wr_en", we_a, 1);
    chk("held_second_addr", longint'(addr_a), 64);

    // Reset after 50 writes abandons the tile.
    cyc = 0;
    while (wcnt_a - w0 < 50 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    chk("writes_before_rst", wcnt_a - w0, 50);
    rst_a = 1'b1; rdy_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0; rdy_a = 1'b1;
    chk("midrst_wr_en", we_a, 0);
    chk("midrst_tile_ready", tr_a, 1);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_addr", longint'(addr_a), 0);
    q_a.delete();
    pix[0] = 0; grp[0] = 0;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (td_a) dcnt++;
      @(posedge clk); #1;
    end
    chk("midrst_no_tile_done", dcnt, 0);

    // Restart from address 0 with a 3-cycle stall on the write to 171400.
    run_tile(0, 20, 3, lat, layer);
    chk("stall_latency", lat, 260);
    chk("stall_layer_done", layer, 0);

    chk("final_queue_a", q_a.size(), 0);
    chk("final_queue_b", q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
